// File: rtl/uart_rx_fifo_if.sv
// Bundle for the receive buffer: the rsr-facing handshake and the host read port.
// The master modport drives (rsr + host side); the slave modport is the buffer.
interface uart_rx_fifo_if #(
  parameter int DATA_SIZE = 7,
  parameter int DEPTH     = 8
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_SIZE-1:0] rx_data;
  logic                 rx_ready;
  logic                 rx_frame_error;
  logic                 rx_ack;
  logic                 rd_en;
  logic [DATA_SIZE-1:0] rd_data;
  logic                 rd_frame_error;
  logic                 empty;
  logic                 full;
  logic [PTR_W:0]       count;
  logic                 overflow;
  logic                 overflow_clr;

  modport master (
    output rx_data, rx_ready, rx_frame_error, rd_en, overflow_clr,
    input  rx_ack, rd_data, rd_frame_error, empty, full, count, overflow
  );

  modport slave (
    input  rx_data, rx_ready, rx_frame_error, rd_en, overflow_clr,
    output rx_ack, rd_data, rd_frame_error, empty, full, count, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: pops characters from the rsr with a four-phase level
// handshake and stores {frame_error, data} in a circular first-word-fall-through FIFO.
module uart_rx_fifo #(
  parameter int DATA_SIZE = 7,
  parameter int DEPTH     = 8
) (
  input logic          clk,
  input logic          reset,
  uart_rx_fifo_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  state_t               state_r;
  state_t               state_s;
  logic [DATA_SIZE:0]   mem_r [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [PTR_W:0]       count_r;
  logic                 overflow_r;
  logic                 capture_s;
  logic                 wr_s;
  logic                 drop_s;
  logic                 pop_s;
  logic                 full_s;
  logic                 empty_s;
  logic [DATA_SIZE:0]   head_s;

  // Occupancy flags come straight from the count; full is judged before any same-cycle pop.
  always_comb begin
    full_s  = (count_r == DEPTH_CNT);
    empty_s = (count_r == '0);
    wr_s    = capture_s & ~full_s;
    drop_s  = capture_s & full_s;
    pop_s   = bus.rd_en & ~empty_s;
  end

  // Capture FSM next state; a character is taken only on the IDLE->ACK edge.
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.rx_ready) begin
          state_s   = ACK;
          capture_s = 1'b1;
        end else begin
          state_s   = IDLE;
        end
      end
      ACK: begin
        if (bus.rx_ready) begin
          state_s = ACK;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Capture FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Storage array: the captured character lands at the write pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_s) begin
      mem_r[wr_ptr_r] <= {bus.rx_frame_error, bus.rx_data};
    end
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
    end
  end

  // Occupancy counter: a simultaneous write and pop leaves it unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else begin
      case ({wr_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overflow; a drop on the same edge as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (bus.overflow_clr) begin
      overflow_r <= 1'b0;
    end
  end

  // Fall-through head entry, forced to zero when nothing is stored.
  always_comb begin
    head_s = mem_r[rd_ptr_r];
    if (empty_s) begin
      bus.rd_data        = '0;
      bus.rd_frame_error = 1'b0;
    end else begin
      bus.rd_data        = head_s[DATA_SIZE-1:0];
      bus.rd_frame_error = head_s[DATA_SIZE];
    end
  end

  assign bus.rx_ack   = (state_r == ACK);
  assign bus.count    = count_r;
  assign bus.empty    = empty_s;
  assign bus.full     = full_s;
  assign bus.overflow = overflow_r;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal pins, then a randomized soak.
module tb_uart_rx_fifo;
  localparam int DS = 7;
  localparam int DP = 8;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  logic [DS:0] q_m [$];
  bit          ovf_m;
  bit          ack_m;

  uart_rx_fifo_if #(.DATA_SIZE(DS), .DEPTH(DP)) bus ();

  uart_rx_fifo #(.DATA_SIZE(DS), .DEPTH(DP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model.
  task automatic compare();
    int exp_data;
    int exp_fe;
    exp_data = 0;
    exp_fe   = 0;
    if (q_m.size() > 0) begin
      exp_data = int'(q_m[0][DS-1:0]);
      exp_fe   = int'(q_m[0][DS]);
    end
    chk("count", int'(bus.count), q_m.size());
    chk("empty", int'(bus.empty), (q_m.size() == 0) ? 1 : 0);
    chk("full", int'(bus.full), (q_m.size() == DP) ? 1 : 0);
    chk("rd_data", int'(bus.rd_data), exp_data);
    chk("rd_frame_error", int'(bus.rd_frame_error), exp_fe);
    chk("overflow", int'(bus.overflow), int'(ovf_m));
    chk("rx_ack", int'(bus.rx_ack), int'(ack_m));
  endtask

  // Advance the model by one edge from the current inputs, clock, then check.
  task automatic step();
    bit cap;
    bit was_full;
    if (reset) begin
      q_m.delete();
      ovf_m = 1'b0;
      ack_m = 1'b0;
    end else begin
      cap      = bus.rx_ready && !ack_m;
      was_full = (q_m.size() == DP);
      if (bus.rd_en && q_m.size() > 0) void'(q_m.pop_front());
      if (cap && !was_full) q_m.push_back({bus.rx_frame_error, bus.rx_data});
      if (cap && was_full) ovf_m = 1'b1;
      else if (bus.overflow_clr) ovf_m = 1'b0;
      ack_m = bus.rx_ready;
    end
    @(posedge clk);
    #1;
    compare();
  endtask

  // Full four-phase transfer of one character, with bounded waits.
  task automatic send_char(input logic [DS-1:0] d, input logic fe);
    bus.rx_data        = d;
    bus.rx_frame_error = fe;
    bus.rx_ready       = 1'b1;
    for (int i = 0; i < 8 && !bus.rx_ack; i++) step();
    chk("ack_wait_rise", int'(bus.rx_ack), 1);
    bus.rx_ready = 1'b0;
    for (int i = 0; i < 8 && bus.rx_ack; i++) step();
    chk("ack_wait_fall", int'(bus.rx_ack), 0);
  endtask

  task automatic pop_one();
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset              = 1'b1;
    bus.rx_data        = '0;
    bus.rx_ready       = 1'b0;
    bus.rx_frame_error = 1'b0;
    bus.rd_en          = 1'b0;
    bus.overflow_clr   = 1'b0;
    step();
    step();
    chk("reset_count", int'(bus.count), 0);
    chk("reset_empty", int'(bus.empty), 1);
    chk("reset_ack", int'(bus.rx_ack), 0);
    reset = 1'b0;
    step();

    // Single character with explicit handshake timing.
    bus.rx_data  = 7'h55;
    bus.rx_ready = 1'b1;
    step();
    chk("single_ack_rise", int'(bus.rx_ack), 1);
    chk("single_count", int'(bus.count), 1);
    chk("single_data", int'(bus.rd_data), 32'h55);
    bus.rx_ready = 1'b0;
    step();
    chk("single_ack_fall", int'(bus.rx_ack), 0);
    pop_one();
    chk("single_pop_empty", int'(bus.empty), 1);
    chk("single_pop_data", int'(bus.rd_data), 0);

    // Held rx_ready writes exactly once.
    bus.rx_data  = 7'h2A;
    bus.rx_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("hold_ack", int'(bus.rx_ack), 1);
      chk("hold_count", int'(bus.count), 1);
    end
    bus.rx_ready = 1'b0;
    step();
    pop_one();

    // Fill, overflow, drain in order.
    for (int i = 1; i <= 8; i++) send_char(DS'(i), (i == 4) ? 1'b1 : 1'b0);
    chk("fill_full", int'(bus.full), 1);
    chk("fill_count", int'(bus.count), 8);
    send_char(7'h7F, 1'b0);
    chk("ninth_overflow", int'(bus.overflow), 1);
    chk("ninth_count", int'(bus.count), 8);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_data", int'(bus.rd_data), i);
      chk("drain_fe", int'(bus.rd_frame_error), (i == 4) ? 1 : 0);
      pop_one();
    end
    chk("drain_empty", int'(bus.empty), 1);
    bus.overflow_clr = 1'b1;
    step();
    bus.overflow_clr = 1'b0;

    // Ninth write coincident with a pop is still dropped.
    for (int i = 1; i <= 8; i++) send_char(DS'(i + 16), 1'b0);
    bus.rx_data  = 7'h7F;
    bus.rx_ready = 1'b1;
    bus.rd_en    = 1'b1;
    step();
    chk("coinc_count", int'(bus.count), 7);
    chk("coinc_overflow", int'(bus.overflow), 1);
    bus.rd_en    = 1'b0;
    bus.rx_ready = 1'b0;
    step();
    send_char(7'h30, 1'b0);
    chk("refill_full", int'(bus.full), 1);
    bus.rx_data      = 7'h31;
    bus.rx_ready     = 1'b1;
    bus.overflow_clr = 1'b1;
    step();
    chk("clr_vs_set", int'(bus.overflow), 1);
    bus.rx_ready = 1'b0;
    step();
    step();
    chk("clr_alone", int'(bus.overflow), 0);
    bus.overflow_clr = 1'b0;
    for (int i = 0; i < 8; i++) pop_one();

    // Write/pop pairs across the pointer wrap.
    send_char(7'h40, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      bus.rx_data  = DS'(7'h40 + k);
      bus.rx_ready = 1'b1;
      bus.rd_en    = 1'b1;
      step();
      chk("wrap_count", int'(bus.count), 1);
      chk("wrap_data", int'(bus.rd_data), 32'h40 + k);
      bus.rx_ready = 1'b0;
      bus.rd_en    = 1'b0;
      step();
    end
    pop_one();
    pop_one();
    chk("empty_pop_count", int'(bus.count), 0);
    chk("empty_pop_data", int'(bus.rd_data), 0);

    // Reset in the middle of a handshake.
    send_char(7'h11, 1'b0);
    send_char(7'h12, 1'b0);
    bus.rx_data  = 7'h13;
    bus.rx_ready = 1'b1;
    step();
    chk("mid_count", int'(bus.count), 3);
    reset = 1'b1;
    step();
    chk("mid_reset_count", int'(bus.count), 0);
    chk("mid_reset_ack", int'(bus.rx_ack), 0);
    reset = 1'b0;
    step();
    chk("recapture_count", int'(bus.count), 1);
    chk("recapture_data", int'(bus.rd_data), 32'h13);
    bus.rx_ready = 1'b0;
    step();

    // Randomized soak, reader bias swept so the FIFO both fills and drains.
    for (int i = 0; i < 3000; i++) begin
      bus.rx_data        = DS'($urandom);
      bus.rx_frame_error = 1'($urandom_range(0, 1));
      bus.rx_ready       = ($urandom_range(0, 99) < 55);
      bus.rd_en          = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 15 : 60));
      bus.overflow_clr   = ($urandom_range(0, 99) < 5);
      reset              = ($urandom_range(0, 999) < 5);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
